// File: rtl/pcie_dma_pkg.sv
// Shared definitions for the PCIe DMA/IO engines: completion fmt/type codes,
// engine state encodings and the per-DW byte swap used on payload data.
package pcie_dma_pkg;

    // {fmt[1:0], type[4:0]} for completions
    localparam logic [6:0]  CPLD_FMT_TYPE  = 7'h4A;  // completion with data
    localparam logic [6:0]  CPL_FMT_TYPE   = 7'h0A;  // completion without data

    // Completion status "successful completion"
    localparam logic [2:0]  CPL_STATUS_SC  = 3'b000;

    // A Cpl reports a fixed byte count of one DW
    localparam logic [11:0] CPL_BYTE_COUNT = 12'd4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_HDR       = 3'd2,
        ST_DATA      = 3'd3,
        ST_DONE      = 3'd4
    } tx_state_t;

    // Memory data is little-endian; TLP payload bytes go out big-endian per DW.
    function automatic logic [31:0] SwapEndianess32(input logic [31:0] dw);
        return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
    endfunction

endpackage

// File: rtl/pcie_cpl_bytecount.sv
// Completion byte-count and lower-address generation from the request's
// first-DW byte enables, length and address. Purely combinational.
module pcie_cpl_bytecount
    import pcie_dma_pkg::*;
(
    input  logic [7:0]  be,
    input  logic [9:0]  len,
    input  logic [12:0] addr,
    input  logic        wd,
    output logic [11:0] byte_count,
    output logic [6:0]  lower_addr
);

    logic [1:0]  offset;
    logic [11:0] single_dw_count;
    logic        unused_bits;

    // Last-DW enables, the DW-aligned address top bits and the byte offset
    // bits of the address do not influence a completion for a 1-DW read.
    assign unused_bits = ^{be[7:4], addr[12:7], addr[1:0]};

    // Byte offset of the first enabled byte within the first DW
    always_comb begin
        offset = 2'b00;
        casez (be[3:0])
            4'b???1: offset = 2'b00;
            4'b??10: offset = 2'b01;
            4'b?100: offset = 2'b10;
            4'b1000: offset = 2'b11;
            default: offset = 2'b00;
        endcase
    end

    // Span from the first to the last enabled byte of a single-DW request
    always_comb begin
        single_dw_count = 12'd1;
        casez (be[3:0])
            4'b1??1: single_dw_count = 12'd4;
            4'b01?1: single_dw_count = 12'd3;
            4'b1?10: single_dw_count = 12'd3;
            4'b0011: single_dw_count = 12'd2;
            4'b0110: single_dw_count = 12'd2;
            4'b1100: single_dw_count = 12'd2;
            default: single_dw_count = 12'd1;
        endcase
    end

    // Select the reported values; len=0 encodes 1024 DW, which wraps to 0
    always_comb begin
        byte_count = CPL_BYTE_COUNT;
        lower_addr = 7'd0;
        if (wd) begin
            lower_addr = {addr[6:2], offset};
            if (len == 10'd1) begin
                byte_count = single_dw_count;
            end else begin
                byte_count = {len, 2'b00};
            end
        end
    end

endmodule

// File: rtl/pcie_io_tx_engine.sv
// PCIe completion transmit engine: builds a 3-DW Cpl/CplD TLP as two 64-bit
// AXI-Stream beats in response to a completion request from the RX side.
module pcie_io_tx_engine
    import pcie_dma_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8
) (
    input  logic                    i_clk,
    input  logic                    i_rst,

    input  logic                    i_s_axis_tx_tready,
    output logic [C_DATA_WIDTH-1:0] o_s_axis_tx_tdata,
    output logic [KEEP_WIDTH-1:0]   o_s_axis_tx_tkeep,
    output logic                    o_s_axis_tx_tlast,
    output logic                    o_s_axis_tx_tvalid,
    output logic [3:0]              o_s_axis_tx_tuser,

    input  logic                    i_req_compl,
    input  logic                    i_req_compl_wd,
    output logic                    o_compl_done,

    input  logic [2:0]              i_req_tc,
    input  logic                    i_req_td,
    input  logic                    i_req_ep,
    input  logic [1:0]              i_req_attr,
    input  logic [9:0]              i_req_len,
    input  logic [15:0]             i_req_rid,
    input  logic [7:0]              i_req_tag,
    input  logic [7:0]              i_req_be,
    input  logic [12:0]             i_req_addr,

    input  logic [15:0]             i_completer_id,

    input  logic                    i_resp_mem_valid,
    input  logic [C_DATA_WIDTH-1:0] i_resp_mem_data
);

    tx_state_t state;
    tx_state_t state_next;

    // Request fields captured when the completion is accepted
    logic [2:0]  tc;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [7:0]  be;
    logic [12:0] addr;
    logic        wd;

    // Read data captured from memory, with a flag saying it is present
    logic [63:0] mem_data;
    logic        data_held;

    logic [11:0] byte_count;
    logic [6:0]  lower_addr;
    logic [31:0] dw0;
    logic [31:0] dw1;
    logic [31:0] dw2;
    logic [31:0] rd_dw;
    logic        accept_data;

    assign o_s_axis_tx_tuser = 4'b0000;

    // Read data is only taken while no TLP is being emitted, so the payload
    // stays stable across backpressure.
    assign accept_data = i_resp_mem_valid &&
                         ((state == ST_IDLE) || (state == ST_WAIT_DATA));

    pcie_cpl_bytecount u_bytecount (
        .be         (be),
        .len        (len),
        .addr       (addr),
        .wd         (wd),
        .byte_count (byte_count),
        .lower_addr (lower_addr)
    );

    assign dw0   = {1'b0, (wd ? CPLD_FMT_TYPE : CPL_FMT_TYPE), 1'b0, tc, 4'b0000,
                    td, ep, attr, 2'b00, (wd ? len : 10'd0)};
    assign dw1   = {i_completer_id, CPL_STATUS_SC, 1'b0, byte_count};
    assign dw2   = {rid, tag, 1'b0, lower_addr};
    assign rd_dw = addr[2] ? mem_data[63:32] : mem_data[31:0];

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the request header fields when a completion is accepted in IDLE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tc   <= 3'd0;
            td   <= 1'b0;
            ep   <= 1'b0;
            attr <= 2'd0;
            len  <= 10'd0;
            rid  <= 16'd0;
            tag  <= 8'd0;
            be   <= 8'd0;
            addr <= 13'd0;
            wd   <= 1'b0;
        end else if ((state == ST_IDLE) && i_req_compl) begin
            tc   <= i_req_tc;
            td   <= i_req_td;
            ep   <= i_req_ep;
            attr <= i_req_attr;
            len  <= i_req_len;
            rid  <= i_req_rid;
            tag  <= i_req_tag;
            be   <= i_req_be;
            addr <= i_req_addr;
            wd   <= i_req_compl_wd;
        end
    end

    // Hold read data until the completion carrying it has been sent
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            mem_data  <= 64'd0;
            data_held <= 1'b0;
        end else if (accept_data) begin
            mem_data  <= i_resp_mem_data;
            data_held <= 1'b1;
        end else if (state == ST_DONE) begin
            data_held <= 1'b0;
        end
    end

    // Next-state and AXI-Stream outputs; outputs depend on state only, so a
    // reset forces tvalid low in the same cycle.
    always_comb begin
        state_next         = state;
        o_s_axis_tx_tvalid = 1'b0;
        o_s_axis_tx_tlast  = 1'b0;
        o_s_axis_tx_tkeep  = '0;
        o_s_axis_tx_tdata  = '0;
        o_compl_done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_req_compl) begin
                    if (!i_req_compl_wd || data_held) begin
                        state_next = ST_HDR;
                    end else begin
                        state_next = ST_WAIT_DATA;
                    end
                end
            end
            ST_WAIT_DATA: begin
                if (data_held || i_resp_mem_valid) begin
                    state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                o_s_axis_tx_tvalid = 1'b1;
                o_s_axis_tx_tkeep  = '1;
                o_s_axis_tx_tdata  = {dw1, dw0};
                if (i_s_axis_tx_tready) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                o_s_axis_tx_tvalid = 1'b1;
                o_s_axis_tx_tlast  = 1'b1;
                if (wd) begin
                    o_s_axis_tx_tkeep = '1;
                    o_s_axis_tx_tdata = {SwapEndianess32(rd_dw), dw2};
                end else begin
                    o_s_axis_tx_tkeep = 8'h0F;
                    o_s_axis_tx_tdata = {32'h0000_0000, dw2};
                end
                if (i_s_axis_tx_tready) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_compl_done = 1'b1;
                state_next   = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pcie_io_tx_engine.sv
// Directed testbench for pcie_io_tx_engine.
module tb_pcie_io_tx_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        tready;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tlast;
    logic        tvalid;
    logic [3:0]  tuser;
    logic        req_compl;
    logic        req_compl_wd;
    logic        compl_done;
    logic [2:0]  req_tc;
    logic        req_td;
    logic        req_ep;
    logic [1:0]  req_attr;
    logic [9:0]  req_len;
    logic [15:0] req_rid;
    logic [7:0]  req_tag;
    logic [7:0]  req_be;
    logic [12:0] req_addr;
    logic [15:0] completer_id;
    logic        resp_mem_valid;
    logic [63:0] resp_mem_data;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] MEM = 64'h11223344_AABBCCDD;
    // Hand-derived byte counts (len=1) and first-byte offsets, one nibble per be[3:0], be=15 at the MSB
    localparam logic [63:0] BC_TAB  = 64'h4342_4341_3231_2111;
    localparam logic [63:0] OFF_TAB = 64'h0102_0103_0102_0100;

    always #5 clk = ~clk;

    pcie_io_tx_engine dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_s_axis_tx_tready (tready),
        .o_s_axis_tx_tdata  (tdata),
        .o_s_axis_tx_tkeep  (tkeep),
        .o_s_axis_tx_tlast  (tlast),
        .o_s_axis_tx_tvalid (tvalid),
        .o_s_axis_tx_tuser  (tuser),
        .i_req_compl        (req_compl),
        .i_req_compl_wd     (req_compl_wd),
        .o_compl_done       (compl_done),
        .i_req_tc           (req_tc),
        .i_req_td           (req_td),
        .i_req_ep           (req_ep),
        .i_req_attr         (req_attr),
        .i_req_len          (req_len),
        .i_req_rid          (req_rid),
        .i_req_tag          (req_tag),
        .i_req_be           (req_be),
        .i_req_addr         (req_addr),
        .i_completer_id     (completer_id),
        .i_resp_mem_valid   (resp_mem_valid),
        .i_resp_mem_data    (resp_mem_data)
    );

    task automatic set_req(input logic wd, input logic [9:0] len, input logic [7:0] be,
                           input logic [12:0] addr, input logic [15:0] rid, input logic [7:0] tag);
        req_compl    = 1'b1;
        req_compl_wd = wd;
        req_len      = len;
        req_be       = be;
        req_addr     = addr;
        req_rid      = rid;
        req_tag      = tag;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({tvalid, tlast, tkeep, tdata} !== 74'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b l=%b k=%h d=%h, expected all zero", tvalid, tlast, tkeep, tdata);
        end
        n_checks++;
        if ({compl_done, tuser} !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_done_tuser: got done=%b tuser=%h, expected 0 0", compl_done, tuser);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({tvalid, compl_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_idle_after_release: got v=%b done=%b, expected 0 0", tvalid, compl_done);
        end
    endtask

    // CplD where the read data arrives after the request (WAIT_DATA path)
    task automatic test_cpld();
        tready = 1'b1;
        set_req(1'b1, 10'd1, 8'h0F, 13'h0010, 16'h0100, 8'h05);
        @(negedge clk);
        req_compl = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL cpld_wait_tvalid[%0d]: got %b expected 0", i, tvalid);
            end
            @(negedge clk);
        end
        resp_mem_valid = 1'b1;
        resp_mem_data  = MEM;
        @(negedge clk);
        resp_mem_valid = 1'b0;
        n_checks++;
        if ({tvalid, tlast, tkeep, tdata} !== {1'b1, 1'b0, 8'hFF, 64'h02000004_4A000001}) begin
            n_fail++;
            $display("FAIL cpld_beat0: got v=%b l=%b k=%h d=%h, expected v=1 l=0 k=ff d=020000044a000001", tvalid, tlast, tkeep, tdata);
        end
        @(negedge clk);
        n_checks++;
        if ({tvalid, tlast, tkeep, tdata} !== {1'b1, 1'b1, 8'hFF, 64'hDDCCBBAA_01000510}) begin
            n_fail++;
            $display("FAIL cpld_beat1: got v=%b l=%b k=%h d=%h, expected v=1 l=1 k=ff d=ddccbbaa01000510", tvalid, tlast, tkeep, tdata);
        end
        @(negedge clk);
        n_checks++;
        if ({compl_done, tvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL cpld_done: got done=%b v=%b, expected 1 0", compl_done, tvalid);
        end
        @(negedge clk);
        n_checks++;
        if (compl_done !== 1'b0) begin
            n_fail++;
            $display("FAIL cpld_done_single: got %b expected 0", compl_done);
        end
    endtask

    // Cpl (no data) with non-zero tc/td/ep/attr and a length that must be reported as 0
    task automatic test_cpl();
        tready   = 1'b1;
        req_tc   = 3'd5;
        req_td   = 1'b1;
        req_ep   = 1'b1;
        req_attr = 2'b01;
        set_req(1'b0, 10'd3, 8'h0F, 13'h1FFF, 16'hABCD, 8'h7E);
        @(negedge clk);
        req_compl = 1'b0;
        req_tc    = 3'd0;
        req_td    = 1'b0;
        req_ep    = 1'b0;
        req_attr  = 2'b00;
        n_checks++;
        if ({tvalid, tlast, tkeep, tdata} !== {1'b1, 1'b0, 8'hFF, 64'h02000004_0A50D000}) begin
            n_fail++;
            $display("FAIL cpl_beat0: got v=%b l=%b k=%h d=%h, expected v=1 l=0 k=ff d=020000040a50d000", tvalid, tlast, tkeep, tdata);
        end
        @(negedge clk);
        n_checks++;
        if ({tvalid, tlast, tkeep, tdata} !== {1'b1, 1'b1, 8'h0F, 64'h00000000_ABCD7E00}) begin
            n_fail++;
            $display("FAIL cpl_beat1: got v=%b l=%b k=%h d=%h, expected v=1 l=1 k=0f d=00000000abcd7e00", tvalid, tlast, tkeep, tdata);
        end
        @(negedge clk);
        n_checks++;
        if ({compl_done, tvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL cpl_done: got done=%b v=%b, expected 1 0", compl_done, tvalid);
        end
        @(negedge clk);
    endtask

    // Data three cycles ahead of the request: HDR, DATA, done at N+1, N+2, N+3
    task automatic test_data_first();
        tready         = 1'b1;
        resp_mem_valid = 1'b1;
        resp_mem_data  = MEM;
        @(negedge clk);
        resp_mem_valid = 1'b0;
        repeat (2) @(negedge clk);
        set_req(1'b1, 10'd2, 8'hFF, 13'h0044, 16'h1234, 8'h9A);
        @(negedge clk);
        req_compl = 1'b0;
        n_checks++;
        if ({tvalid, tlast, tkeep, tdata} !== {1'b1, 1'b0, 8'hFF, 64'h02000008_4A000002}) begin
            n_fail++;
            $display("FAIL early_beat0: got v=%b l=%b k=%h d=%h, expected v=1 l=0 k=ff d=020000084a000002", tvalid, tlast, tkeep, tdata);
        end
        @(negedge clk);
        n_checks++;
        if ({tvalid, tlast, tkeep, tdata} !== {1'b1, 1'b1, 8'hFF, 64'h44332211_12349A44}) begin
            n_fail++;
            $display("FAIL early_beat1: got v=%b l=%b k=%h d=%h, expected v=1 l=1 k=ff d=4433221112349a44", tvalid, tlast, tkeep, tdata);
        end
        @(negedge clk);
        n_checks++;
        if (compl_done !== 1'b1) begin
            n_fail++;
            $display("FAIL early_done: got %b expected 1", compl_done);
        end
        @(negedge clk);
    endtask

    // len=0 (1024 DW, count wraps to 0) and len=1023
    task automatic test_len_boundary();
        logic [9:0]  len;
        logic [63:0] exp0;
        tready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            len  = (i == 0) ? 10'd0 : 10'h3FF;
            exp0 = (i == 0) ? 64'h02000000_4A000000 : 64'h02000FFC_4A0003FF;
            resp_mem_valid = 1'b1;
            resp_mem_data  = MEM;
            @(negedge clk);
            resp_mem_valid = 1'b0;
            set_req(1'b1, len, 8'hFF, 13'h0000, 16'h0001, 8'h01);
            @(negedge clk);
            req_compl = 1'b0;
            n_checks++;
            if ({tvalid, tdata} !== {1'b1, exp0}) begin
                n_fail++;
                $display("FAIL len_beat0 len=%0d: got v=%b d=%h, expected v=1 d=%h", len, tvalid, tdata, exp0);
            end
            repeat (2) @(negedge clk);
            n_checks++;
            if (compl_done !== 1'b1) begin
                n_fail++;
                $display("FAIL len_done len=%0d: got %b expected 1", len, compl_done);
            end
            @(negedge clk);
        end
    endtask

    // All 16 first-DW byte-enable patterns; odd be values use addr[2]=0, even use addr[2]=1
    task automatic test_be_sweep();
        logic [12:0] addr;
        logic [3:0]  bcn;
        logic [3:0]  offn;
        logic [6:0]  la;
        logic [63:0] exp0;
        logic [63:0] exp1;
        tready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            addr = (b % 2 == 1) ? 13'h0028 : 13'h0034;
            bcn  = BC_TAB[b*4 +: 4];
            offn = OFF_TAB[b*4 +: 4];
            la   = {addr[6:2], offn[1:0]};
            exp0 = {16'h0200, 4'h0, 8'h00, bcn, 32'h4A000001};
            exp1 = {((b % 2 == 1) ? 32'hDDCCBBAA : 32'h44332211), 16'h0100, 8'(b), 1'b0, la};
            resp_mem_valid = 1'b1;
            resp_mem_data  = MEM;
            @(negedge clk);
            resp_mem_valid = 1'b0;
            set_req(1'b1, 10'd1, {4'hA, 4'(b)}, addr, 16'h0100, 8'(b));
            @(negedge clk);
            req_compl = 1'b0;
            n_checks++;
            if ({tvalid, tdata} !== {1'b1, exp0}) begin
                n_fail++;
                $display("FAIL sweep_beat0 be=%h: got v=%b d=%h, expected v=1 d=%h", b[3:0], tvalid, tdata, exp0);
            end
            @(negedge clk);
            n_checks++;
            if ({tvalid, tlast, tdata} !== {1'b1, 1'b1, exp1}) begin
                n_fail++;
                $display("FAIL sweep_beat1 be=%h: got v=%b l=%b d=%h, expected v=1 l=1 d=%h", b[3:0], tvalid, tlast, tdata, exp1);
            end
            @(negedge clk);
            n_checks++;
            if (compl_done !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_done be=%h: got %b expected 1", b[3:0], compl_done);
            end
            @(negedge clk);
        end
    endtask

    // Stalls in HDR and DATA, plus a request arriving mid-TLP that must be ignored
    task automatic test_backpressure();
        int dones;
        tready         = 1'b0;
        resp_mem_valid = 1'b1;
        resp_mem_data  = MEM;
        @(negedge clk);
        resp_mem_valid = 1'b0;
        set_req(1'b1, 10'd1, 8'h0F, 13'h0010, 16'h0100, 8'h05);
        @(negedge clk);
        req_compl = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({tvalid, tlast, tkeep, tdata} !== {1'b1, 1'b0, 8'hFF, 64'h02000004_4A000001}) begin
                n_fail++;
                $display("FAIL bp_hdr_hold[%0d]: got v=%b l=%b k=%h d=%h, expected v=1 l=0 k=ff d=020000044a000001", i, tvalid, tlast, tkeep, tdata);
            end
            if (i == 1) set_req(1'b0, 10'd7, 8'h01, 13'h0000, 16'hFFFF, 8'hEE);
            if (i == 2) req_compl = 1'b0;
            if (i == 4) tready = 1'b1;
            @(negedge clk);
        end
        tready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if ({tvalid, tlast, tkeep, tdata, compl_done} !== {1'b1, 1'b1, 8'hFF, 64'hDDCCBBAA_01000510, 1'b0}) begin
                n_fail++;
                $display("FAIL bp_data_hold[%0d]: got v=%b l=%b k=%h d=%h done=%b, expected v=1 l=1 k=ff d=ddccbbaa01000510 done=0", j, tvalid, tlast, tkeep, tdata, compl_done);
            end
            if (j == 2) tready = 1'b1;
            @(negedge clk);
        end
        dones = 0;
        for (int k = 0; k < 5; k++) begin
            if (compl_done === 1'b1) dones++;
            if (k > 0) begin
                n_checks++;
                if (tvalid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_ignored_req[%0d]: got tvalid=%b expected 0", k, tvalid);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (dones != 1) begin
            n_fail++;
            $display("FAIL bp_done_count: got %0d expected 1", dones);
        end
    endtask

    // Reset while stalled in DATA: tvalid drops at once, nothing resumes, held data is lost
    task automatic test_reset_mid_tlp();
        tready         = 1'b0;
        resp_mem_valid = 1'b1;
        resp_mem_data  = MEM;
        @(negedge clk);
        resp_mem_valid = 1'b0;
        set_req(1'b1, 10'd1, 8'h0F, 13'h0010, 16'h0100, 8'h05);
        @(negedge clk);
        req_compl = 1'b0;
        tready    = 1'b1;
        @(negedge clk);
        tready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({tvalid, tlast} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_pre_data: got v=%b l=%b, expected 1 1", tvalid, tlast);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({tvalid, tlast, tkeep, tdata} !== 74'd0) begin
            n_fail++;
            $display("FAIL rst_async_drop: got v=%b l=%b k=%h d=%h, expected all zero", tvalid, tlast, tkeep, tdata);
        end
        @(negedge clk);
        rst    = 1'b0;
        tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({tvalid, compl_done} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_no_resume[%0d]: got v=%b done=%b, expected 0 0", i, tvalid, compl_done);
            end
        end
        set_req(1'b1, 10'd1, 8'h0F, 13'h0010, 16'h0100, 8'h05);
        @(negedge clk);
        req_compl = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (tvalid !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_flag_cleared[%0d]: got tvalid=%b expected 0", i, tvalid);
            end
            @(negedge clk);
        end
        resp_mem_valid = 1'b1;
        @(negedge clk);
        resp_mem_valid = 1'b0;
        n_checks++;
        if ({tvalid, tdata} !== {1'b1, 64'h02000004_4A000001}) begin
            n_fail++;
            $display("FAIL rst_recover_beat0: got v=%b d=%h, expected v=1 d=020000044a000001", tvalid, tdata);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (compl_done !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_recover_done: got %b expected 1", compl_done);
        end
        @(negedge clk);
    endtask

    initial begin
        rst            = 1'b0;
        tready         = 1'b0;
        req_compl      = 1'b0;
        req_compl_wd   = 1'b0;
        req_tc         = 3'd0;
        req_td         = 1'b0;
        req_ep         = 1'b0;
        req_attr       = 2'd0;
        req_len        = 10'd0;
        req_rid        = 16'd0;
        req_tag        = 8'd0;
        req_be         = 8'd0;
        req_addr       = 13'd0;
        completer_id   = 16'h0200;
        resp_mem_valid = 1'b0;
        resp_mem_data  = 64'd0;
        #1 rst = 1'b1;
        test_reset();
        test_cpld();
        test_cpl();
        test_data_first();
        test_len_boundary();
        test_be_sweep();
        test_backpressure();
        test_reset_mid_tlp();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pcie_io_tx_engine.md
PCIE_IO_TX_ENGINE -- requirements
Module: pcie_io_tx_engine

Interface
REQ-001 SHALL have parameters: C_DATA_WIDTH, default 64, AXIS data width (only 64 supported); KEEP_WIDTH, default C_DATA_WIDTH/8, tkeep width.
REQ-002 SHALL have ports (name  direction  width  meaning):
- i_clk  in  1  system bus clock; one clock for the whole block
- i_rst  in  1  reset; asynchronous, active-high
- i_s_axis_tx_tready  in  1  core accepts beat
- o_s_axis_tx_tdata  out  64  TLP beat
- o_s_axis_tx_tkeep  out  8  byte valid
- o_s_axis_tx_tlast  out  1  last beat
- o_s_axis_tx_tvalid  out  1  beat valid
- o_s_axis_tx_tuser  out  4  tied 0
- i_req_compl  in  1  completion requested
- i_req_compl_wd  in  1  1=CplD (with data), 0=Cpl (no data)
- o_compl_done  out  1  one-cycle pulse, completion sent
- i_req_tc  in  3 / i_req_td  in  1 / i_req_ep  in  1 / i_req_attr  in  2 / i_req_len  in  10  request header fields
- i_req_rid  in  16 / i_req_tag  in  8 / i_req_be  in  8 / i_req_addr  in  13  requester ID, tag, byte enables, address
- i_completer_id  in  16  bus/dev/func of this endpoint
- i_resp_mem_valid  in  1  read data valid
- i_resp_mem_data  in  64  read data (little-endian)

Function
REQ-003 SHALL implement states IDLE, WAIT_DATA, HDR, DATA, DONE.
REQ-004 IDLE: when i_req_compl=1, SHALL latch all i_req_* fields and i_req_compl_wd, then go to HDR if Cpl or data already latched, else WAIT_DATA.
REQ-005 SHALL latch i_resp_mem_data and set a data-held flag on any cycle i_resp_mem_valid=1 in IDLE or WAIT_DATA; flag clears on DONE. Same-cycle i_req_compl and i_resp_mem_valid SHALL both be captured.
REQ-006 WAIT_DATA: SHALL go to HDR the cycle after data is latched.
REQ-007 HDR: tvalid=1, tkeep=8'hFF, tlast=0; tdata[31:0]=DW0 {1'b0, fmt(2'b10 CplD / 2'b00 Cpl), type 5'b01010, 1'b0, tc, 4'b0, td, ep, attr, 2'b0, len (CplD: i_req_len; Cpl: 10'd0)}; tdata[63:32]=DW1 {completer_id, status 3'b000, BCM 0, byte_count[11:0]}.
REQ-008 HDR to DATA only on tready=1; tdata/tkeep/tlast/tvalid SHALL hold stable while tready=0.
REQ-009 DATA: tvalid=1, tlast=1; tdata[31:0]=DW2 {rid, tag, 1'b0, lower_addr[6:0]}; CplD: tkeep=8'hFF, tdata[63:32]=selected read DW (upper half if req_addr[2]=1, else lower) byte-swapped per 32-bit word; Cpl: tkeep=8'h0F, tdata[63:32]=0.
REQ-010 DATA to DONE on tready=1; DONE SHALL pulse o_compl_done=1 one cycle, tvalid=0, then IDLE.
REQ-011 CplD, len=1: byte_count from be[3:0]: 1xx1->4; 01x1, 1x10->3; 0011, 0110, 1100->2; single bit->1; 0000->1. len>1: byte_count=len*4, truncated to 12 bits (len=0 -> 1024*4 -> 12'd0).
REQ-012 lower_addr = {req_addr[6:2], offset}, offset = index of lowest set bit of be[3:0] (00 if be=0). Cpl: byte_count=12'd4, lower_addr=7'd0.
REQ-013 i_req_compl while not in IDLE SHALL be ignored.
REQ-014 Latency, tready=1, data held: request in cycle N -> HDR at N+1, DATA at N+2, o_compl_done at N+3.

Reset
REQ-015 On i_rst=1, asynchronously: state=IDLE, tvalid=0, tlast=0, tkeep=0, tdata=0, o_compl_done=0, data-held flag=0, all latches 0.
REQ-016 Reset mid-TLP SHALL drop tvalid immediately; no partial TLP resumes after reset.

Structure
REQ-017 Completion fmt/type constants (CPLD 7'h4A, CPL 7'h0A), state encodings and the SwapEndianess32 function SHALL live in shared package pcie_dma_pkg, shared with the RX engine.
REQ-018 Byte-count/lower-address logic SHALL be sub-module pcie_cpl_bytecount (combinational; inputs be, len, addr, wd).

Verification
REQ-019 CplD: compl=1, wd=1, len=1, be=8'h0F, addr=13'h0010, rid=16'h0100, tag=8'h05, completer=16'h0200, data=64'h11223344_AABBCCDD -> beat0 = 64'h02000004_4A000001, beat1 = 64'hDDCCBBAA_01000510, tkeep FF, tlast on beat1, done pulse.
REQ-020 Cpl: wd=0, be=8'h0F -> beat0 fmt/type 7'h0A, len 0, byte_count 4; beat1 tkeep=8'h0F, lower_addr 0.
REQ-021 Backpressure: tready=0 for 5 cycles in HDR and 3 in DATA -> tdata/tvalid held unchanged, one done pulse.
REQ-022 Data before request: resp_mem_valid 3 cycles before compl -> WAIT_DATA skipped, latency per REQ-014.
REQ-023 be sweep: all 16 be[3:0] values -> byte_count/lower_addr per REQ-011/012; addr[2]=1 selects upper DW.
REQ-024 Reset asserted during DATA with tready=0 -> tvalid=0 same cycle, IDLE, no done pulse.
